fsm_lockstep_sequencer: RTL

- Controller for the 3-bit cycle state machine and its three implementations: behavioural case, gate-level and ROM-based.
- Holds all three implementations in reset, releases them together, then drives the shared `a` input from a programmed bit pattern, one bit per clock.
- Compares the three `s` outputs every run cycle and reports mismatches, illegal output codes, the index of the first failure and a pass/fail verdict.
- Sits between the bench (or a host register block) and the three FSM instances.

---
 rtl/fsm_lockstep_sequencer_pkg.sv | 25 ++
 rtl/fsm_lockstep_sequencer_if.sv | 39 +++
 rtl/lockstep_cmp.sv | 16 +
 rtl/fsm_lockstep_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fsm_lockstep_sequencer_pkg.sv
// Shared definitions for the lockstep sequencer: controller state encoding,
// the set of legal FSM output codes and default parameter values.
package fsm_lockstep_sequencer_pkg;

  localparam int DEF_PAT_W   = 16;
  localparam int DEF_LEN_W   = 5;
  localparam int DEF_RST_CYC = 2;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // One bit per 3-bit code; a set bit marks a code the cycle FSM may emit
  // (0, 2, 3, 4, 5).
  localparam logic [7:0] LEGAL_CODES = 8'b0011_1101;

  function automatic logic is_legal(input logic [2:0] s);
    return LEGAL_CODES[s];
  endfunction

endpackage

// File: rtl/fsm_lockstep_sequencer_if.sv
// Handshake and observation signals between the host side (start, pattern,
// length and the three FSM outputs) and the lockstep sequencer.
interface fsm_lockstep_sequencer_if
  import fsm_lockstep_sequencer_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic [2:0]       s_beh;
  logic [2:0]       s_gate;
  logic [2:0]       s_rom;
  logic             fsm_res;
  logic             fsm_a;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] mism_cnt;
  logic [LEN_W-1:0] first_idx;
  logic             first_vld;
  logic             illegal;

  // Host / FSM-array side.
  modport master (
    output start, pattern, length, s_beh, s_gate, s_rom,
    input  fsm_res, fsm_a, busy, done, pass, mism_cnt, first_idx, first_vld, illegal
  );

  // Sequencer side.
  modport slave (
    input  start, pattern, length, s_beh, s_gate, s_rom,
    output fsm_res, fsm_a, busy, done, pass, mism_cnt, first_idx, first_vld, illegal
  );

endinterface

// File: rtl/lockstep_cmp.sv
// Three-way lockstep comparator: flags any disagreement between the three
// FSM outputs and any output code outside the legal set. Purely combinational.
module lockstep_cmp
  import fsm_lockstep_sequencer_pkg::*;
(
  input  logic [2:0] s0_i,
  input  logic [2:0] s1_i,
  input  logic [2:0] s2_i,
  output logic       mismatch_o,
  output logic       illegal_o
);

  assign mismatch_o = (s0_i != s1_i) || (s1_i != s2_i);
  assign illegal_o  = !(is_legal(s0_i) && is_legal(s1_i) && is_legal(s2_i));

endmodule

// File: rtl/fsm_lockstep_sequencer.sv
// Lockstep sequencer: holds the three FSM implementations in reset, releases
// them together, plays a latched bit pattern on their shared `a` input and
// compares their outputs every run cycle, producing a verdict at the end.
module fsm_lockstep_sequencer
  import fsm_lockstep_sequencer_pkg::*;
#(
  parameter int PAT_W   = DEF_PAT_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int RST_CYC = DEF_RST_CYC,
  parameter int CNT_W   = DEF_CNT_W
)(
  input  logic                      clk,
  input  logic                      reset,
  fsm_lockstep_sequencer_if.slave   bus
);

  localparam int HC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [HC_W-1:0]  hold_q, hold_d;
  logic             fsm_res_q, fsm_res_d;
  logic             fsm_a_q, fsm_a_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic [LEN_W-1:0] first_idx_q, first_idx_d;
  logic             first_vld_q, first_vld_d;
  logic             illegal_q, illegal_d;

  logic             cmp_mism, cmp_ill, cmp_fail;
  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] idx_nxt;
  logic             pat_bit_nxt;
  logic [CNT_W-1:0] mism_inc;

  lockstep_cmp u_cmp (
    .s0_i       (bus.s_beh),
    .s1_i       (bus.s_gate),
    .s2_i       (bus.s_rom),
    .mismatch_o (cmp_mism),
    .illegal_o  (cmp_ill)
  );

  assign cmp_fail    = cmp_mism | cmp_ill;
  assign len_clamped = (bus.length > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.length;
  assign idx_nxt     = idx_q + LEN_W'(1);
  assign pat_bit_nxt = |(pat_q & (PAT_W'(1) << idx_nxt));
  assign mism_inc    = (mism_q == '1) ? mism_q : mism_q + CNT_W'(1);

  // Next-state and next-output decode for the run controller.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    pat_d       = pat_q;
    len_d       = len_q;
    idx_d       = idx_q;
    hold_d      = hold_q;
    fsm_res_d   = fsm_res_q;
    fsm_a_d     = fsm_a_q;
    pass_d      = pass_q;
    mism_d      = mism_q;
    first_idx_d = first_idx_q;
    first_vld_d = first_vld_q;
    illegal_d   = illegal_q;

    unique case (state_q)
      ST_IDLE: begin
        fsm_res_d = 1'b1;
        fsm_a_d   = 1'b0;
        if (bus.start) begin
          pat_d       = bus.pattern;
          len_d       = len_clamped;
          mism_d      = '0;
          first_vld_d = 1'b0;
          illegal_d   = 1'b0;
          pass_d      = 1'b0;
          hold_d      = HC_W'(RST_CYC - 1);
          fsm_res_d   = 1'b0;
          state_d     = ST_HOLD;
        end
      end

      ST_HOLD: begin
        fsm_res_d = 1'b0;
        fsm_a_d   = 1'b0;
        if (hold_q == '0) begin
          // Release all three FSMs on the same edge that presents bit 0.
          state_d   = ST_RUN;
          idx_d     = '0;
          fsm_res_d = 1'b1;
          fsm_a_d   = (len_q != '0) ? pat_q[0] : 1'b0;
        end else begin
          hold_d = hold_q - HC_W'(1);
        end
      end

      ST_RUN: begin
        fsm_res_d = 1'b1;
        if (cmp_fail) begin
          mism_d = mism_inc;
          if (!first_vld_q) begin
            first_idx_d = idx_q;
            first_vld_d = 1'b1;
          end
        end
        if (cmp_ill) begin
          illegal_d = 1'b1;
        end
        if (idx_q == len_q) begin
          // Drain compare done; verdict includes this final cycle.
          state_d = ST_DONE;
          fsm_a_d = 1'b0;
          pass_d  = (mism_d == '0) && !illegal_d;
        end else begin
          idx_d   = idx_nxt;
          fsm_a_d = (idx_nxt < len_q) ? pat_bit_nxt : 1'b0;
        end
      end

      ST_DONE: begin
        fsm_res_d = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any run immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      hold_q      <= '0;
      fsm_res_q   <= 1'b0;
      fsm_a_q     <= 1'b0;
      pass_q      <= 1'b0;
      mism_q      <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values and the update order cannot matter.
      state_q     <= state_d;
      pat_q       <= pat_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      fsm_res_q   <= fsm_res_d;
      fsm_a_q     <= fsm_a_d;
      pass_q      <= pass_d;
      mism_q      <= mism_d;
      first_idx_q <= first_idx_d;
      first_vld_q <= first_vld_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.fsm_res   = fsm_res_q;
  assign bus.fsm_a     = fsm_a_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.mism_cnt  = mism_q;
  assign bus.first_idx = first_idx_q;
  assign bus.first_vld = first_vld_q;
  assign bus.illegal   = illegal_q;

endmodule
